// File: rtl/alu_mdu_unit.sv
// Integer execution unit: single-cycle logic/arith/shift ops plus an iterative
// unsigned multiply/divide unit that writes HI/LO, read back through MFHI/MFLO.
module alu_mdu_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // the requester must hold funct/dataA/dataB stable until then. out_valid is a
    // one-cycle pulse with no back-pressure, one per accepted request.

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               ready_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [WIDTH-1:0]   cand;
    logic               dbz_q;
    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;

    // ready_q keeps in_ready low while reset is asserted and for the first edge after.
    assign in_ready = ready_q && (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && funct == F_MULTU) begin
                    state_next = MUL;
                end else if (accept && funct == F_DIVU) begin
                    state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (funct)
            F_AND:  alu_res = dataA & dataB;
            F_OR:   alu_res = dataA | dataB;
            F_ADD:  alu_res = dataA + dataB;
            F_SUB:  alu_res = dataA - dataB;
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            F_SLL:  alu_res = dataA << dataB[SHAMT_W-1:0];
            F_SRL:  alu_res = dataA >> dataB[SHAMT_W-1:0];
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiply: partial product in work_hi, multiplier shifts out of work_lo.
    assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, cand} : '0);

    // Restoring divide: remainder in work_hi, quotient bits shift into work_lo.
    // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, cand});
    assign div_diff  = div_shift[WIDTH-1:0] - cand;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            cand        <= '0;
            dbz_q       <= 1'b0;
            result      <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (funct == F_MULTU) begin
                            work_hi <= '0;
                            work_lo <= dataB;
                            cand    <= dataA;
                            cnt     <= SHAMT_W'(WIDTH - 1);
                            dbz_q   <= 1'b0;
                        end else if (funct == F_DIVU) begin
                            work_hi <= '0;
                            work_lo <= dataA;
                            cand    <= dataB;
                            cnt     <= SHAMT_W'(WIDTH - 1);
                            dbz_q   <= (dataB == '0);
                        end else begin
                            result    <= alu_res;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    work_hi <= mul_sum[WIDTH:1];
                    work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    cnt     <= cnt - SHAMT_W'(1);
                end
                DIV: begin
                    work_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    cnt     <= cnt - SHAMT_W'(1);
                end
                DONE: begin
                    hi          <= work_hi;
                    lo          <= work_lo;
                    result      <= work_lo;
                    out_valid   <= 1'b1;
                    div_by_zero <= dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Scoreboard bench for alu_mdu_unit: directed vectors push {div_by_zero, result}
// expectations; a negedge monitor pops one per out_valid pulse.
module tb_alu_mdu_unit;

    localparam int WIDTH = 32;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [5:0]       funct = '0;
    logic [WIDTH-1:0] dataA = '0;
    logic [WIDTH-1:0] dataB = '0;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic             busy;

    alu_mdu_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct      (funct),
        .dataA      (dataA),
        .dataB      (dataB),
        .out_valid  (out_valid),
        .result     (result),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=%h expected=none", {div_by_zero, result});
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {div_by_zero, result}, e);
            end
        end
    end

    // Present a request and hold it until accepted; returns the accept edge number.
    task automatic send(input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit push, input logic [WIDTH:0] e, output int acc);
        int t;
        t = 0;
        funct    = f;
        dataA    = a;
        dataB    = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
            in_valid = 1'b0;
            acc = -1;
        end else begin
            if (push) exp_q.push_back(e);
            @(posedge clk);
            #1;
            acc = cyc;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        funct    = 6'd63;
        dataA    = 32'hDEAD_BEEF;
        dataB    = 32'h1234_5678;
    endtask

    // Wait for out_valid, counting cycles where the unit was not reporting busy.
    task automatic wait_ov(output int ov_cyc, output int bad);
        int t;
        t = 0;
        bad = 0;
        ov_cyc = -1;
        while (t < 100) begin
            @(negedge clk);
            t++;
            if (out_valid) begin
                ov_cyc = cyc;
                break;
            end
            if (in_ready || !busy) bad++;
        end
        if (ov_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout actual=none required=pulse");
        end
    endtask

    initial begin
        int acc;
        int acc0;
        int m;
        int ov;
        int bad;
        int t;

        repeat (2) @(negedge clk);
        check("reset_result", {1'b0, result}, '0);
        check("reset_flags", {30'd0, out_valid, div_by_zero, busy}, '0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {32'd0, in_ready}, 33'd1);

        // ADD wraps; result one edge after accept
        send(F_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1, {1'b0, 32'h0000_0000}, acc);
        check("add_latency", {32'd0, out_valid}, 33'd1);
        idle();
        @(negedge clk);

        // back-to-back single-cycle ops, including shift-amount masking and unknown funct
        send(F_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, {1'b0, 32'h00F0_000F}, acc0);
        send(F_OR,  32'hF000_0000, 32'h0000_000F, 1, {1'b0, 32'hF000_000F}, acc);
        send(F_SUB, 32'h0000_0005, 32'h0000_0007, 1, {1'b0, 32'hFFFF_FFFE}, acc);
        send(F_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1, {1'b0, 32'h0000_0001}, acc);
        send(F_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 1, {1'b0, 32'h0000_0000}, acc);
        send(F_SLL, 32'h0000_0001, 32'h0000_0021, 1, {1'b0, 32'h0000_0002}, acc);
        send(F_SRL, 32'h8000_0000, 32'h0000_001F, 1, {1'b0, 32'h0000_0001}, acc);
        send(F_SRL, 32'h8000_0000, 32'h0000_0020, 1, {1'b0, 32'h8000_0000}, acc);
        send(6'd63, 32'h1234_5678, 32'h1111_1111, 1, {1'b0, 32'h0000_0000}, acc);
        check("back_to_back", 33'(acc - acc0), 33'd8);
        idle();
        @(negedge clk);

        // MULTU max*max, operands disturbed while busy
        send(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, {1'b0, 32'h0000_0001}, m);
        idle();
        funct = F_DIVU;
        wait_ov(ov, bad);
        check("mul_busy_ready", 33'(bad), 33'd0);
        check("mul_latency", 33'(ov - m), 33'(WIDTH + 1));
        send(F_MFHI, '0, '0, 1, {1'b0, 32'hFFFF_FFFE}, acc);
        send(F_MFLO, '0, '0, 1, {1'b0, 32'h0000_0001}, acc);
        idle();

        // DIVU 100/7 and divide by zero
        send(F_DIVU, 32'd100, 32'd7, 1, {1'b0, 32'd14}, m);
        idle();
        wait_ov(ov, bad);
        check("div_latency", 33'(ov - m), 33'(WIDTH + 1));
        send(F_MFHI, '0, '0, 1, {1'b0, 32'd2}, acc);
        send(F_MFLO, '0, '0, 1, {1'b0, 32'd14}, acc);
        send(F_DIVU, 32'd5, 32'd0, 1, {1'b1, 32'hFFFF_FFFF}, m);
        idle();
        wait_ov(ov, bad);
        check("div0_latency", 33'(ov - m), 33'(WIDTH + 1));
        send(F_MFHI, '0, '0, 1, {1'b0, 32'd5}, acc);
        send(F_MFLO, '0, '0, 1, {1'b0, 32'hFFFF_FFFF}, acc);
        idle();
        @(negedge clk);

        // ADD held during MULTU busy is accepted on the first ready cycle
        send(F_MULTU, 32'd3, 32'd4, 1, {1'b0, 32'd12}, m);
        send(F_ADD, 32'd10, 32'd20, 1, {1'b0, 32'd30}, acc);
        check("held_accept", 33'(acc - m), 33'(WIDTH + 2));
        send(F_MFHI, '0, '0, 1, {1'b0, 32'd0}, acc);
        send(F_MFLO, '0, '0, 1, {1'b0, 32'd12}, acc);
        idle();
        repeat (3) @(negedge clk);

        // reset during MULTU aborts it and clears HI/LO
        send(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, '0, m);
        idle();
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_flags", {31'd0, out_valid, busy}, '0);
        reset = 1'b1;
        send(F_MFHI, '0, '0, 1, {1'b0, 32'd0}, acc);
        send(F_MFLO, '0, '0, 1, {1'b0, 32'd0}, acc);
        idle();

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("queue_drain", 33'(exp_q.size()), 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
